control_unit: RTL and testbench

- Multicycle Moore FSM that drives every control wire of the CPU datapath: muxes, register loads, memory, IR, register bank and ALU.
- Sits directly upstream of the datapath. Consumes the IR opcode and funct fields plus the ALU status flags.
- Supported set: R-type add/sub/and, addi, lw, sw, beq, bne, j, with exceptions for invalid opcode and overflow.

---
 rtl/control_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_control_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the CPU datapath: fetch, decode, R/I-type ALU ops,
// load/store, branches, jump and the invalid-opcode/overflow exception entry sequence.
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       Overflow,
    input  logic       Zero,
    output logic       PcWrite,
    output logic       Load_A,
    output logic       Load_B,
    output logic       ALUout_Load,
    output logic       EPCwrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [2:0] IorD,
    output logic [2:0] ExCause,
    output logic [2:0] WR_REG,
    output logic [3:0] WD_REG,
    output logic [2:0] ALUSrcA,
    output logic [2:0] ALUSrcB,
    output logic [2:0] PcSource,
    output logic [2:0] ALUOp,
    output logic [1:0] LoadCtrl,
    output logic [1:0] StoreCtrl,
    output logic       SingExCtrl
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_AND    = 6'h24;

    typedef enum logic [4:0] {
        S_RST, S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
        S_RALU, S_RWB, S_IALU, S_IWB,
        S_ADDR, S_MRD0, S_MRD1, S_LWB, S_SWR,
        S_BR, S_JMP, S_EXC0, S_EXC1, S_EXC2
    } state_t;

    state_t state;
    state_t state_next;
    logic   cause;
    logic   exc_cause;

    // State register; the exception cause is captured only on entry to EXC0
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RST;
            cause <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == S_EXC0) begin
                cause <= exc_cause;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        exc_cause  = 1'b0;
        case (state)
            S_RST:    state_next = S_FETCH0;
            S_FETCH0: state_next = S_FETCH1;
            S_FETCH1: state_next = S_FETCH2;
            S_FETCH2: state_next = S_DECODE;
            S_DECODE: begin
                case (OP)
                    OP_RTYPE: begin
                        if (Funct == F_ADD || Funct == F_SUB || Funct == F_AND) begin
                            state_next = S_RALU;
                        end else begin
                            state_next = S_EXC0;
                        end
                    end
                    OP_ADDI:       state_next = S_IALU;
                    OP_LW, OP_SW:  state_next = S_ADDR;
                    OP_BEQ, OP_BNE: state_next = S_BR;
                    OP_J:          state_next = S_JMP;
                    default:       state_next = S_EXC0;
                endcase
            end
            S_RALU: begin
                if (Overflow && Funct != F_AND) begin
                    state_next = S_EXC0;
                    exc_cause  = 1'b1;
                end else begin
                    state_next = S_RWB;
                end
            end
            S_IALU: begin
                if (Overflow) begin
                    state_next = S_EXC0;
                    exc_cause  = 1'b1;
                end else begin
                    state_next = S_IWB;
                end
            end
            S_ADDR:   state_next = (OP == OP_LW) ? S_MRD0 : S_SWR;
            S_MRD0:   state_next = S_MRD1;
            S_MRD1:   state_next = S_LWB;
            S_EXC0:   state_next = S_EXC1;
            S_EXC1:   state_next = S_EXC2;
            S_RWB, S_IWB, S_LWB, S_SWR, S_BR, S_JMP, S_EXC2: state_next = S_FETCH0;
            default:  state_next = S_RST;
        endcase
    end

    assign LoadCtrl   = 2'd0;
    assign StoreCtrl  = 2'd0;
    assign SingExCtrl = 1'b0;

    // Output decode; everything is forced low while reset is held
    always_comb begin
        PcWrite     = 1'b0;
        Load_A      = 1'b0;
        Load_B      = 1'b0;
        ALUout_Load = 1'b0;
        EPCwrite    = 1'b0;
        MemWrite    = 1'b0;
        MemRead     = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        IorD        = 3'd0;
        ExCause     = 3'd0;
        WR_REG      = 3'd0;
        WD_REG      = 4'd0;
        ALUSrcA     = 3'd0;
        ALUSrcB     = 3'd0;
        PcSource    = 3'd0;
        ALUOp       = 3'd0;
        if (reset) begin
            case (state)
                S_RST: begin
                    RegWrite = 1'b1;
                    WR_REG   = 3'd2;
                    WD_REG   = 4'd2;
                end
                S_FETCH0, S_FETCH1: MemRead = 1'b1;
                S_FETCH2: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    ALUSrcB = 3'd1;
                    ALUOp   = 3'd1;
                    PcWrite = 1'b1;
                end
                S_DECODE: begin
                    Load_A      = 1'b1;
                    Load_B      = 1'b1;
                    ALUSrcB     = 3'd3;
                    ALUOp       = 3'd1;
                    ALUout_Load = 1'b1;
                end
                S_RALU: begin
                    ALUSrcA     = 3'd1;
                    ALUout_Load = 1'b1;
                    case (Funct)
                        F_SUB:   ALUOp = 3'd2;
                        F_AND:   ALUOp = 3'd3;
                        default: ALUOp = 3'd1;
                    endcase
                end
                S_RWB: begin
                    RegWrite = 1'b1;
                    WR_REG   = 3'd1;
                end
                S_IALU, S_ADDR: begin
                    ALUSrcA     = 3'd1;
                    ALUSrcB     = 3'd2;
                    ALUOp       = 3'd1;
                    ALUout_Load = 1'b1;
                end
                S_IWB: RegWrite = 1'b1;
                S_MRD0, S_MRD1: begin
                    IorD    = 3'd2;
                    MemRead = 1'b1;
                end
                S_LWB: begin
                    RegWrite = 1'b1;
                    WD_REG   = 4'd1;
                end
                S_SWR: begin
                    IorD     = 3'd2;
                    MemWrite = 1'b1;
                end
                S_BR: begin
                    ALUSrcA  = 3'd1;
                    ALUOp    = 3'd2;
                    PcSource = 3'd1;
                    PcWrite  = (OP == OP_BNE) ? ~Zero : Zero;
                end
                S_JMP: begin
                    PcSource = 3'd2;
                    PcWrite  = 1'b1;
                end
                S_EXC0: begin
                    EPCwrite = 1'b1;
                    ALUSrcB  = 3'd1;
                    ALUOp    = 3'd2;
                    IorD     = 3'd1;
                    ExCause  = {2'b00, cause};
                    MemRead  = 1'b1;
                end
                S_EXC1: begin
                    IorD    = 3'd1;
                    ExCause = {2'b00, cause};
                    MemRead = 1'b1;
                end
                S_EXC2: begin
                    PcSource = 3'd3;
                    PcWrite  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit: per-instruction output sequences plus
// reset release and reset-abandons-load sequences.
module tb_control_unit;

    typedef logic [38:0] word_t;

    typedef struct {
        string            name;
        logic [5:0]       op;
        logic [5:0]       funct;
        logic             ovf;
        logic             zero;
        int               n;
        logic [3:0][38:0] exp;
    } vec_t;

    localparam logic [8:0] PCW = 9'b1_0000_0000;
    localparam logic [8:0] LA  = 9'b0_1000_0000;
    localparam logic [8:0] LB  = 9'b0_0100_0000;
    localparam logic [8:0] AOL = 9'b0_0010_0000;
    localparam logic [8:0] EPC = 9'b0_0001_0000;
    localparam logic [8:0] MW  = 9'b0_0000_1000;
    localparam logic [8:0] MR  = 9'b0_0000_0100;
    localparam logic [8:0] IRW = 9'b0_0000_0010;
    localparam logic [8:0] RW  = 9'b0_0000_0001;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       overflow, zero;
    logic       pc_write, load_a, load_b, aluout_load, epc_write, mem_write, mem_read, ir_write, reg_write;
    logic [2:0] iord, ex_cause, wr_reg, alu_src_a, alu_src_b, pc_source, alu_op;
    logic [3:0] wd_reg;
    logic [1:0] load_ctrl, store_ctrl;
    logic       sing_ex_ctrl;

    int n_cmp = 0;
    int n_bad = 0;
    vec_t vq[$];

    control_unit dut (
        .clk(clk), .reset(reset), .OP(op), .Funct(funct), .Overflow(overflow), .Zero(zero),
        .PcWrite(pc_write), .Load_A(load_a), .Load_B(load_b), .ALUout_Load(aluout_load),
        .EPCwrite(epc_write), .MemWrite(mem_write), .MemRead(mem_read), .IRWrite(ir_write),
        .RegWrite(reg_write), .IorD(iord), .ExCause(ex_cause), .WR_REG(wr_reg), .WD_REG(wd_reg),
        .ALUSrcA(alu_src_a), .ALUSrcB(alu_src_b), .PcSource(pc_source), .ALUOp(alu_op),
        .LoadCtrl(load_ctrl), .StoreCtrl(store_ctrl), .SingExCtrl(sing_ex_ctrl)
    );

    always #5 clk = ~clk;

    word_t outs;
    assign outs = {pc_write, load_a, load_b, aluout_load, epc_write, mem_write, mem_read, ir_write,
                   reg_write, iord, ex_cause, wr_reg, wd_reg, alu_src_a, alu_src_b, pc_source,
                   alu_op, load_ctrl, store_ctrl, sing_ex_ctrl};

    function automatic word_t w(input logic [8:0] en, input int unsigned io, exc, wr, wd,
                                input int unsigned sa, sb, ps, ao);
        return {en, 3'(io), 3'(exc), 3'(wr), 4'(wd), 3'(sa), 3'(sb), 3'(ps), 3'(ao),
                2'b00, 2'b00, 1'b0};
    endfunction

    task automatic check(input string tag, input word_t exp);
        word_t act;
        act = outs;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [5:0] o, input logic [5:0] f,
                           input logic ov, input logic z, input int n,
                           input word_t e0, input word_t e1, input word_t e2, input word_t e3);
        vec_t v;
        v.name  = nm;
        v.op    = o;
        v.funct = f;
        v.ovf   = ov;
        v.zero  = z;
        v.n     = n;
        v.exp   = {e3, e2, e1, e0};
        vq.push_back(v);
    endtask

    initial begin
        word_t w_zero, w_rst, w_f0, w_f2, w_dec, w_radd, w_rsub, w_rand, w_rwb, w_ialu, w_iwb;
        word_t w_mrd, w_lwb, w_swr, w_br_t, w_br_n, w_jmp, w_e0c0, w_e1c0, w_e0c1, w_e1c1, w_e2;
        word_t fd[4];
        word_t ex;

        w_zero = '0;
        w_rst  = w(RW, 0, 0, 2, 2, 0, 0, 0, 0);
        w_f0   = w(MR, 0, 0, 0, 0, 0, 0, 0, 0);
        w_f2   = w(MR | IRW | PCW, 0, 0, 0, 0, 0, 1, 0, 1);
        w_dec  = w(LA | LB | AOL, 0, 0, 0, 0, 0, 3, 0, 1);
        w_radd = w(AOL, 0, 0, 0, 0, 1, 0, 0, 1);
        w_rsub = w(AOL, 0, 0, 0, 0, 1, 0, 0, 2);
        w_rand = w(AOL, 0, 0, 0, 0, 1, 0, 0, 3);
        w_rwb  = w(RW, 0, 0, 1, 0, 0, 0, 0, 0);
        w_ialu = w(AOL, 0, 0, 0, 0, 1, 2, 0, 1);
        w_iwb  = w(RW, 0, 0, 0, 0, 0, 0, 0, 0);
        w_mrd  = w(MR, 2, 0, 0, 0, 0, 0, 0, 0);
        w_lwb  = w(RW, 0, 0, 0, 1, 0, 0, 0, 0);
        w_swr  = w(MW, 2, 0, 0, 0, 0, 0, 0, 0);
        w_br_t = w(PCW, 0, 0, 0, 0, 1, 0, 1, 2);
        w_br_n = w(9'd0, 0, 0, 0, 0, 1, 0, 1, 2);
        w_jmp  = w(PCW, 0, 0, 0, 0, 0, 0, 2, 0);
        w_e0c0 = w(EPC | MR, 1, 0, 0, 0, 0, 1, 0, 2);
        w_e1c0 = w(MR, 1, 0, 0, 0, 0, 0, 0, 0);
        w_e0c1 = w(EPC | MR, 1, 1, 0, 0, 0, 1, 0, 2);
        w_e1c1 = w(MR, 1, 1, 0, 0, 0, 0, 0, 0);
        w_e2   = w(PCW, 0, 0, 0, 0, 0, 0, 3, 0);
        fd = '{w_f0, w_f0, w_f2, w_dec};

        add_vec("add",        6'h00, 6'h20, 1'b0, 1'b0, 2, w_radd, w_rwb, '0, '0);
        add_vec("sub",        6'h00, 6'h22, 1'b0, 1'b1, 2, w_rsub, w_rwb, '0, '0);
        add_vec("and_ovf",    6'h00, 6'h24, 1'b1, 1'b0, 2, w_rand, w_rwb, '0, '0);
        add_vec("sub_ovf",    6'h00, 6'h22, 1'b1, 1'b0, 4, w_rsub, w_e0c1, w_e1c1, w_e2);
        add_vec("addi",       6'h08, 6'h3F, 1'b0, 1'b0, 2, w_ialu, w_iwb, '0, '0);
        add_vec("addi_ovf",   6'h08, 6'h01, 1'b1, 1'b0, 4, w_ialu, w_e0c1, w_e1c1, w_e2);
        add_vec("lw_ovf_ign", 6'h23, 6'h00, 1'b1, 1'b1, 4, w_ialu, w_mrd, w_mrd, w_lwb);
        add_vec("sw",         6'h2B, 6'h04, 1'b1, 1'b0, 2, w_ialu, w_swr, '0, '0);
        add_vec("beq_z1",     6'h04, 6'h00, 1'b0, 1'b1, 1, w_br_t, '0, '0, '0);
        add_vec("beq_z0",     6'h04, 6'h00, 1'b0, 1'b0, 1, w_br_n, '0, '0, '0);
        add_vec("bne_z0",     6'h05, 6'h00, 1'b0, 1'b0, 1, w_br_t, '0, '0, '0);
        add_vec("bne_z1",     6'h05, 6'h00, 1'b1, 1'b1, 1, w_br_n, '0, '0, '0);
        add_vec("j",          6'h02, 6'h00, 1'b1, 1'b0, 1, w_jmp, '0, '0, '0);
        add_vec("bad_op",     6'h3F, 6'h20, 1'b0, 1'b0, 3, w_e0c0, w_e1c0, w_e2, '0);
        add_vec("bad_funct",  6'h00, 6'h25, 1'b1, 1'b0, 3, w_e0c0, w_e1c0, w_e2, '0);
        add_vec("add_ovf",    6'h00, 6'h20, 1'b1, 1'b0, 4, w_radd, w_e0c1, w_e1c1, w_e2);

        // Reset held, then released: RST for one cycle
        reset = 1'b0;
        op = 6'h00; funct = 6'h00; overflow = 1'b0; zero = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_held", w_zero);
        reset = 1'b1;
        #1;
        check("rst_state", w_rst);
        @(negedge clk);

        foreach (vq[i]) begin
            op       = vq[i].op;
            funct    = vq[i].funct;
            overflow = vq[i].ovf;
            zero     = vq[i].zero;
            #1;
            for (int k = 0; k < 4 + vq[i].n; k++) begin
                if (k > 0) @(negedge clk);
                ex = (k < 4) ? fd[k] : word_t'(vq[i].exp[k-4]);
                check($sformatf("%s[%0d]", vq[i].name, k), ex);
            end
            @(negedge clk);
        end
        check("back_to_fetch0", w_f0);

        // lw abandoned by reset during MRD1; restart at RST, no LWB write
        op = 6'h23; funct = 6'h00; overflow = 1'b0; zero = 1'b0;
        repeat (6) @(negedge clk);
        check("lw_mrd1", w_mrd);
        reset = 1'b0;
        #1;
        check("lw_reset_now", w_zero);
        @(negedge clk);
        check("lw_reset_hold", w_zero);
        reset = 1'b1;
        #1;
        check("lw_restart_rst", w_rst);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ex = (k < 4) ? fd[k] : w_ialu;
            check($sformatf("lw_restart[%0d]", k), ex);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
